// File: rtl/rst_button_conditioner_if.sv
// Pushbutton-side signal bundle for rst_button_conditioner.
// master: the button/stimulus side; slave: the conditioner.
// oLONG exists only when RST_COND_LONGPRESS_EN is defined.
interface rst_button_conditioner_if;
    logic iKEY_n;
    logic oRST_n;
    logic oPRESS;
    logic oBUSY;
`ifdef RST_COND_LONGPRESS_EN
    logic oLONG;
`endif

    modport master (
        output iKEY_n,
        input  oRST_n,
        input  oPRESS,
        input  oBUSY
`ifdef RST_COND_LONGPRESS_EN
        , input oLONG
`endif
    );

    modport slave (
        input  iKEY_n,
        output oRST_n,
        output oPRESS,
        output oBUSY
`ifdef RST_COND_LONGPRESS_EN
        , output oLONG
`endif
    );
endinterface

// File: rtl/rst_button_conditioner.sv
// Reset pushbutton conditioner: synchronises an active-low bouncing key,
// debounces press and release, and drives an active-low reset command that
// stays low for at least HOLD_CYC cycles plus a debounced release.
// Optional long-press detector is enabled by defining RST_COND_LONGPRESS_EN.
module rst_button_conditioner #(
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned DEBOUNCE_CYC = 20'd1000000,
    parameter int unsigned HOLD_CYC     = 16'd50000
`ifdef RST_COND_LONGPRESS_EN
    , parameter int unsigned LONG_CYC   = 28'd150000000
`endif
) (
    input  logic                     iCLK,
    input  logic                     iRST,
    rst_button_conditioner_if.slave  btn
);

    localparam int unsigned CNT_MAX = (DEBOUNCE_CYC > HOLD_CYC) ? DEBOUNCE_CYC : HOLD_CYC;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        DB_PRESS,
        ASSERT,
        WAIT_REL,
        DB_REL
    } stateT;

    logic [SYNC_STAGES-1:0] keySync;
    logic                   keyS;

    stateT            state;
    stateT            stateNxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cntNxt;
    logic             rstNNxt;
    logic             pressNxt;
    logic             rstNReg;
    logic             pressReg;

    // Synchroniser chain for the asynchronous key; idles high (released)
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            keySync <= '1;
        end else begin
            keySync <= {keySync[SYNC_STAGES-2:0], btn.iKEY_n};
        end
    end

    assign keyS = keySync[SYNC_STAGES-1];

    // State, shared counter and registered outputs
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state    <= IDLE;
            cnt      <= '0;
            rstNReg  <= 1'b1;
            pressReg <= 1'b0;
        end else begin
            state    <= stateNxt;
            cnt      <= cntNxt;
            rstNReg  <= rstNNxt;
            pressReg <= pressNxt;
        end
    end

    // Next-state, counter and output decode; outputs follow the next state
    // so that oRST_n and oPRESS change on the same edge as the transition
    always_comb begin
        stateNxt = state;
        cntNxt   = cnt;
        pressNxt = 1'b0;
        rstNNxt  = 1'b1;

        case (state)
            IDLE: begin
                if (!keyS) begin
                    stateNxt = DB_PRESS;
                end
            end
            DB_PRESS: begin
                if (keyS) begin
                    stateNxt = IDLE;
                end else if (cnt == DEB_LAST) begin
                    stateNxt = ASSERT;
                    pressNxt = 1'b1;
                end else begin
                    cntNxt = cnt + CNT_W'(1);
                end
            end
            ASSERT: begin
                if (cnt == HOLD_LAST) begin
                    stateNxt = WAIT_REL;
                end else begin
                    cntNxt = cnt + CNT_W'(1);
                end
            end
            WAIT_REL: begin
                if (keyS) begin
                    stateNxt = DB_REL;
                end
            end
            DB_REL: begin
                if (!keyS) begin
                    stateNxt = WAIT_REL;
                end else if (cnt == DEB_LAST) begin
                    stateNxt = IDLE;
                end else begin
                    cntNxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                stateNxt = IDLE;
            end
        endcase

        if (stateNxt != state) begin
            cntNxt = '0;
        end

        rstNNxt = (stateNxt == IDLE) || (stateNxt == DB_PRESS);
    end

    assign btn.oRST_n = rstNReg;
    assign btn.oPRESS = pressReg;
    assign btn.oBUSY  = (state != IDLE);

`ifdef RST_COND_LONGPRESS_EN
    localparam int unsigned LONG_W = $clog2(LONG_CYC + 1);
    localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYC - 1);
    localparam logic [LONG_W-1:0] LONG_DONE = LONG_W'(LONG_CYC);

    logic [LONG_W-1:0] longCnt;
    logic              longReg;

    // Long-press timer: runs from ASSERT entry, parks at LONG_DONE after its
    // single chance to fire so a press yields at most one oLONG pulse
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            longCnt <= '0;
            longReg <= 1'b0;
        end else begin
            longReg <= 1'b0;
            if ((state == IDLE) || (state == DB_PRESS)) begin
                longCnt <= '0;
            end else if (longCnt == LONG_LAST) begin
                longCnt <= LONG_DONE;
                longReg <= (state == ASSERT) || (state == WAIT_REL);
            end else if (longCnt < LONG_LAST) begin
                longCnt <= longCnt + LONG_W'(1);
            end
        end
    end

    assign btn.oLONG = longReg;
`endif

endmodule

// File: tb/tb_rst_button_conditioner.sv
// Bench for rst_button_conditioner: directed scenarios plus random key
// activity, every cycle compared against a run-length reference model.
module tb_rst_button_conditioner;

    localparam int unsigned SYNC = 2;
    localparam int unsigned DEB  = 8;
    localparam int unsigned HOLD = 4;
`ifdef RST_COND_LONGPRESS_EN
    localparam int unsigned LONGC = 40;
`endif
    localparam int unsigned PRESS_LAT = SYNC + DEB + 1;
    localparam int unsigned REL_LAT   = SYNC + DEB + 1;
    localparam int unsigned MIN_LOW   = HOLD + DEB + 1;

    logic iCLK = 1'b0;
    logic iRST;

    rst_button_conditioner_if bif ();

    rst_button_conditioner #(
        .SYNC_STAGES  (SYNC),
        .DEBOUNCE_CYC (DEB),
        .HOLD_CYC     (HOLD)
`ifdef RST_COND_LONGPRESS_EN
        , .LONG_CYC   (LONGC)
`endif
    ) dut (
        .iCLK (iCLK),
        .iRST (iRST),
        .btn  (bif)
    );

    always #5 iCLK = ~iCLK;

    int nChecks = 0;
    int nFails  = 0;
    int pressCount = 0;
    int longCount  = 0;

    // Reference model state: key delay line and run lengths of the
    // synchronised key, plus the age of the current assertion
    int keyHist[$];
    bit mAsserted;
    int zeroRun;
    int oneRun;
    int since;
    bit expRstN;
    bit expPress;
    bit expBusy;
    bit expLong;

    task automatic checkVal(input string tag, input logic [31:0] got, input int exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic modelStep(input bit key, input bit rst);
        bit s;
`ifdef RST_COND_LONGPRESS_EN
        bit inAW;
`endif
        expPress = 1'b0;
        expLong  = 1'b0;
        if (rst) begin
            keyHist = {};
            repeat (SYNC) keyHist.push_back(1);
            mAsserted = 1'b0;
            zeroRun   = 0;
            oneRun    = 0;
            since     = 0;
        end else begin
            s = keyHist[SYNC-1][0];
            keyHist.push_front(int'(key));
            void'(keyHist.pop_back());
            if (!mAsserted) begin
                zeroRun = s ? 0 : zeroRun + 1;
                if (zeroRun == DEB + 1) begin
                    mAsserted = 1'b1;
                    expPress  = 1'b1;
                    since     = 0;
                    oneRun    = 0;
                end
            end else begin
                since++;
`ifdef RST_COND_LONGPRESS_EN
                inAW = (since <= HOLD) || (oneRun == 0);
                if (since == LONGC && inAW) expLong = 1'b1;
`endif
                if (since > HOLD) begin
                    oneRun = s ? oneRun + 1 : 0;
                    if (oneRun == DEB + 1) begin
                        mAsserted = 1'b0;
                        zeroRun   = 0;
                    end
                end
            end
        end
        expRstN = !mAsserted;
        expBusy = mAsserted || (zeroRun > 0);
    endtask

    task automatic tick(input bit key, input bit rst);
        bif.iKEY_n = key;
        iRST       = rst;
        @(posedge iCLK);
        modelStep(key, rst);
        @(negedge iCLK);
        checkVal("oRST_n", bif.oRST_n, int'(expRstN));
        checkVal("oPRESS", bif.oPRESS, int'(expPress));
        checkVal("oBUSY", bif.oBUSY, int'(expBusy));
        if (bif.oPRESS === 1'b1) pressCount++;
`ifdef RST_COND_LONGPRESS_EN
        checkVal("oLONG", bif.oLONG, int'(expLong));
        if (bif.oLONG === 1'b1) longCount++;
`endif
    endtask

    task automatic doReset();
        repeat (3) tick(1'b1, 1'b1);
        pressCount = 0;
        longCount  = 0;
    endtask

    // Hold the key low until the press is accepted; returns ticks taken
    task automatic pressUntilAssert(output int n);
        n = 0;
        do begin
            tick(1'b0, 1'b0);
            n++;
        end while (bif.oRST_n !== 1'b0 && n < 100);
    endtask

    // Hold the key high until oRST_n releases; returns ticks taken
    task automatic releaseUntilIdle(output int n);
        n = 0;
        do begin
            tick(1'b1, 1'b0);
            n++;
        end while (bif.oRST_n !== 1'b1 && n < 100);
    endtask

    initial begin
        int n;
        int w;
        bit rnd;
        bif.iKEY_n = 1'b1;
        iRST       = 1'b1;

        // Reset state
        doReset();
        checkVal("reset_rstN", bif.oRST_n, 1);
        checkVal("reset_press", bif.oPRESS, 0);
        checkVal("reset_busy", bif.oBUSY, 0);

        // Clean press held 30 cycles, then release
        pressUntilAssert(n);
        checkVal("press_latency", n, PRESS_LAT);
        checkVal("press_pulse_at_fall", bif.oPRESS, 1);
        repeat (30 - n) tick(1'b0, 1'b0);
        checkVal("single_press_pulse", pressCount, 1);
        releaseUntilIdle(n);
        checkVal("release_latency", n, REL_LAT);
        checkVal("idle_busy", bif.oBUSY, 0);
`ifdef RST_COND_LONGPRESS_EN
        checkVal("no_long_30", longCount, 0);
`endif

        // Bounce: 5 low, 1 high, 5 low, then high
        doReset();
        repeat (5) tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        repeat (5) tick(1'b0, 1'b0);
        repeat (15) tick(1'b1, 1'b0);
        checkVal("bounce_no_press", pressCount, 0);
        checkVal("bounce_rstN", bif.oRST_n, 1);
        checkVal("bounce_idle", bif.oBUSY, 0);

        // Short press released as soon as it is accepted
        doReset();
        pressUntilAssert(n);
        w = 1;
        n = 0;
        do begin
            tick(1'b1, 1'b0);
            n++;
            if (bif.oRST_n === 1'b0) w++;
        end while (bif.oRST_n === 1'b0 && n < 100);
        checkVal("min_low_width", w, MIN_LOW);

        // Release bounce while waiting for release
        doReset();
        pressUntilAssert(n);
        repeat (20) tick(1'b0, 1'b0);
        repeat (3) tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        checkVal("rel_bounce_held", bif.oRST_n, 0);
        releaseUntilIdle(n);
        checkVal("rel_bounce_latency", n, REL_LAT);

        // Block reset while waiting for release with the key still held
        doReset();
        pressUntilAssert(n);
        repeat (20) tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        checkVal("midrst_rstN", bif.oRST_n, 1);
        checkVal("midrst_busy", bif.oBUSY, 0);
        pressCount = 0;
        pressUntilAssert(n);
        checkVal("midrst_relatency", n, PRESS_LAT);
        checkVal("midrst_repress", pressCount, 1);
        releaseUntilIdle(n);

`ifdef RST_COND_LONGPRESS_EN
        // Long hold: one oLONG pulse LONGC edges after assertion
        doReset();
        pressUntilAssert(n);
        w = 0;
        n = 0;
        repeat (60) begin
            tick(1'b0, 1'b0);
            n++;
            if (bif.oLONG === 1'b1 && w == 0) w = n;
        end
        checkVal("long_count", longCount, 1);
        checkVal("long_delay", w, LONGC);
        releaseUntilIdle(n);
`endif

        // Random key activity with occasional block resets
        doReset();
        for (int i = 0; i < 120; i++) begin
            int lowLen;
            int highLen;
            lowLen  = $urandom_range(1, 30);
            highLen = $urandom_range(1, 25);
            for (int j = 0; j < lowLen; j++) begin
                rnd = ($urandom_range(0, 199) == 0);
                tick(1'b0, rnd);
            end
            for (int j = 0; j < highLen; j++) begin
                rnd = ($urandom_range(0, 199) == 0);
                tick(1'b1, rnd);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
